// File: rtl/bin2bcd_seq_pkg.sv
// Shared defaults, FSM states and counter sizing for the sequential
// shift-and-add-3 binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must hold the value WIDTH itself, so it never wraps mid-conversion.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit corrector: adds 3 when the digit is 5 or more so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// with a registered result, sign and leading-zero blanking mask.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int ACC_W = DIGITS * 4;
  localparam int CW    = cnt_width(WIDTH);
  localparam logic [CW-1:0]     LAST_ITER = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS - 1){1'b1}}, 1'b0};

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic               sign_lat_reg;

  logic               busy_reg;
  logic               done_reg;
  logic [ACC_W-1:0]   bcd_reg;
  logic               sign_out_reg;
  logic [DIGITS-1:0]  blank_reg;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_next;
  logic [DIGITS-1:0]  blank_next;
  logic               sign_out_next;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_in  (acc_reg[gi*4 +: 4]),
        .digit_out (acc_adj[gi*4 +: 4])
      );
    end
  endgenerate

  // The corrected top digit never carries out for a correctly sized DIGITS,
  // so truncating the shifted-out MSB loses nothing.
  assign acc_next = ACC_W'({acc_adj, shift_reg[WIDTH-1]});

  always_comb begin
    logic zero_above;
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (acc_reg[i*4 +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  assign sign_out_next = sign_lat_reg & (|acc_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      shift_reg    <= '0;
      sign_lat_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      sign_out_reg <= 1'b0;
      blank_reg    <= BLANK_RST;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg    <= bin;
            acc_reg      <= '0;
            sign_lat_reg <= sign_in;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_reg << 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          bcd_reg      <= acc_reg;
          sign_out_reg <= sign_out_next;
          blank_reg    <= blank_next;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign sign_out = sign_out_reg;
  assign blank    = blank_reg;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16, is the binary input width.
REQ-002 Parameter DIGITS, default 5, is the BCD output digit count; DIGITS*4 >= bits needed for 2^WIDTH-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request pulse from multiplier done; samples bin and sign_in.
REQ-006 bin  input  WIDTH  unsigned magnitude of the product.
REQ-007 sign_in  input  1  product sign, 1 = negative.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when bcd, sign_out and blank are valid.
REQ-010 bcd  output  DIGITS*4  packed BCD result, digit 0 in bits [3:0].
REQ-011 sign_out  output  1  registered copy of sign_in for the result.
REQ-012 blank  output  DIGITS  per-digit leading-zero mask for the display stage, 1 = blank.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: busy=0, done=0; on start=1 load shift register with bin, clear BCD accumulator, latch sign_in, clear iteration counter, go to SHIFT.
REQ-015 SHIFT: each cycle, add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one; increment counter.
REQ-016 SHIFT -> DONE after exactly WIDTH iterations; counter is $clog2(WIDTH+1) bits and never wraps within a conversion.
REQ-017 DONE: update bcd, sign_out, blank from accumulator; done=1 this cycle only; go to IDLE next cycle.
REQ-018 Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH+1 (edge k+17 for WIDTH=16).
REQ-019 busy=1 in SHIFT and DONE, 0 in IDLE.
REQ-020 start asserted while busy=1 is ignored; no queueing, in-flight conversion unaffected.
REQ-021 start in the cycle state returns to IDLE (DONE cycle) is ignored; start one cycle later is accepted.
REQ-022 bcd, sign_out, blank hold last valid result between done pulses.
REQ-023 blank[i]=1 iff digit i and all higher digits are zero, for i >= 1; blank[0] is always 0 (zero displays "0").
REQ-024 sign_out is forced to 0 when result equals zero (no "-0").
REQ-025 bin = 2^WIDTH-1 converts correctly; no overflow output exists.

Reset
REQ-026 rst=1 at an edge forces IDLE regardless of state, including mid-SHIFT; the partial conversion is discarded.
REQ-027 Reset values: busy=0, done=0, bcd=0, sign_out=0, blank={DIGITS-1 ones, 0}, counter=0, accumulator=0.
REQ-028 rst has priority over start in the same cycle.

Structure
REQ-029 Shared package holds WIDTH and DIGITS defaults, the FSM state enumeration, and the counter-width constant.
REQ-030 One sub-module, bcd_digit_adj: combinational 4-bit add-3-if->=5 corrector, instantiated DIGITS times.
REQ-031 All outputs registered; no combinational path from start or bin to any output.

Verification
REQ-032 bin=16384, sign_in=1, start pulse -> done at edge k+17, bcd=0x16384, sign_out=1, blank=00000.
REQ-033 bin=0, sign_in=1 -> bcd=0x00000, sign_out=0, blank=11110.
REQ-034 bin=65535 -> bcd=0x65535; bin=42 -> bcd=0x00042, blank=11100.
REQ-035 start bin=123, then start bin=999 five cycles later -> single done, bcd=0x00123, second request ignored.
REQ-036 rst pulse at iteration 8 of bin=500 -> IDLE next cycle, busy=0, no done, bcd=0; new start bin=7 -> bcd=0x00007.
REQ-037 start on the cycle after done -> accepted, second done exactly 18 cycles after first.
